singleport_ram_ctrl: RTL and testbench

Request/response front-end for the single-port tristate RAM (wr_en, rd_en, addr, shared dinout bus, one-cycle registered read, output enable delayed by one cycle).
- Accepts read/write requests on a valid/ready interface and issues them to the RAM.
- Enforces bus turnaround on the shared data bus.
- Captures read data and returns it through a response FIFO with backpressure.
- Sits between a bus master or DMA engine and the RAM instance.

---
 rtl/singleport_ram_ctrl.sv | 98 +++++++++
 tb/tb_singleport_ram_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/singleport_ram_ctrl.sv
// Valid/ready front-end for a single-port RAM with a shared tristate data bus.
// Issues commands combinationally, enforces write-after-read turnaround and returns reads through a credit-guarded FIFO.
module singleport_ram_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int RSP_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  inout  wire  [WIDTH-1:0]         ram_dinout
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  logic              r_rd_pend;
  logic [WIDTH-1:0]  r_fifo [RSP_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic [CW-1:0]     w_inflight;
  logic              w_credit_ok;
  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  logic              w_push;
  logic              w_pop;

  // Credit ignores a same-cycle pop so the ready path never depends on rsp_ready.
  assign w_inflight  = r_count + CW'(r_rd_pend);
  assign w_credit_ok = (w_inflight < CW'(RSP_DEPTH));

  assign req_ready = rst_n & ~(r_rd_pend & req_we) & (req_we | w_credit_ok);

  assign w_accept = req_valid & req_ready;
  assign w_wr     = w_accept & req_we;
  assign w_rd     = w_accept & ~req_we;

  assign ram_wr_en  = w_wr;
  assign ram_rd_en  = w_rd;
  assign ram_addr   = w_accept ? req_addr : '0;
  assign ram_dinout = w_wr ? req_wdata : {WIDTH{1'bz}};

  // While rd_pend is high the RAM owns the bus; its value lands in the FIFO at the edge.
  assign w_push = r_rd_pend;
  assign w_pop  = (r_count != '0) & rsp_ready;

  assign rsp_valid = (r_count != '0);
  assign rsp_data  = r_fifo[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_rd_pend <= w_rd;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= ram_dinout;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_bus_contention: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_rd_pend && w_wr));

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == CW'(RSP_DEPTH))));

  a_no_fifo_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_pop && (r_count == '0)));

endmodule

// File: tb/tb_singleport_ram_ctrl.sv
// Bench for singleport_ram_ctrl: behavioural tristate RAM, directed vector table,
// hand sequences for throughput / reset corners, and a random run against a memory model.
module tb_singleport_ram_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             ram_wr_en;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_addr;
  wire  [WIDTH-1:0] ram_dinout;

  singleport_ram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RSP_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .ram_wr_en  (ram_wr_en),
    .ram_rd_en  (ram_rd_en),
    .ram_addr   (ram_addr),
    .ram_dinout (ram_dinout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAM: registered read, output enable one cycle after rd_en
  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic [WIDTH-1:0] ram_q;
  logic             ram_oe;
  assign ram_dinout = ram_oe ? ram_q : {WIDTH{1'bz}};

  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_addr] <= ram_dinout;
    if (ram_rd_en) ram_q <= ram_mem[ram_addr];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_oe <= 1'b0;
    else        ram_oe <= ram_rd_en;
  end

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_mem [DEPTH];
  int checks;
  int failures;
  int n_contention;
  logic acc_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    logic [WIDTH-1:0] e;
    #1;
    acc_flag = req_valid && req_ready;
    if (rst_n) begin
      if (ram_wr_en && ram_oe) n_contention++;
      if (acc_flag) begin
        if (req_we) model_mem[req_addr] = req_wdata;
        else        exp_q.push_back(model_mem[req_addr]);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_rsp", 32'(rsp_data), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("sb_rsp_data", 32'(rsp_data), 32'(e));
        end
      end
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d, input logic rr);
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    settle();
  endtask

  typedef struct {
    logic             v;
    logic             we;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             rr;
    logic             e_rdy;
    logic             e_wr;
    logic             e_rd;
    logic             e_rv;
    logic [WIDTH-1:0] e_data;
  } vec_t;

  vec_t vecs [26];

  initial begin
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;
    logic             rwe;
    int               stall;

    checks = 0; failures = 0; n_contention = 0; acc_flag = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // write 3=A5 then read it; read-to-write turnaround; credit exhaustion with rsp_ready low
    vecs[0]  = '{1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b1, 4'd2, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 4'd2, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[9]  = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E};
    vecs[12] = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[14] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[15] = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[16] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[17] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[18] = '{1'b1, 1'b1, 4'd5, 8'h5C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[19] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[20] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E};
    vecs[21] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[22] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[23] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E};
    vecs[24] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[25] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    // reset state, with a request offered during reset
    @(negedge clk);
    req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_wr_en",     32'(ram_wr_en), 32'd0);
    chk("rst_rd_en",     32'(ram_rd_en), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].rr);
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_wr_en", i),     32'(ram_wr_en), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_rd_en", i),     32'(ram_rd_en), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_ram_addr", i),  32'(ram_addr),
          (vecs[i].e_wr || vecs[i].e_rd) ? 32'(vecs[i].a) : 32'd0);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_data));
      if (vecs[i].e_wr) chk($sformatf("v%0d_bus", i), 32'(ram_dinout), 32'(vecs[i].d));
    end

    // back-to-back reads: full throughput, ordered responses one per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'(i), 8'(i * 3), 1'b1);
      chk("fill_ready", 32'(req_ready), 32'd1);
    end
    for (int k = 0; k < 18; k++) begin
      drive(k < 16, 1'b0, 4'(k), 8'h00, 1'b1);
      if (k < 16) chk($sformatf("b2b_ready_%0d", k), 32'(req_ready), 32'd1);
      if (k >= 2) begin
        chk($sformatf("b2b_rsp_valid_%0d", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("b2b_rsp_data_%0d", k),  32'(rsp_data),  32'((k - 2) * 3));
      end else begin
        chk($sformatf("b2b_rsp_valid_%0d", k), 32'(rsp_valid), 32'd0);
      end
    end
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("b2b_drained", 32'(rsp_valid), 32'd0);

    // restore addresses used below, then reset with two entries queued and a read in flight
    drive(1'b1, 1'b1, 4'd5, 8'h5C, 1'b1);
    drive(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5; rsp_ready = 1'b0;
    #1;
    chk("midrst_pre_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data",  32'(rsp_data),  32'd0);
    chk("midrst_rd_en",     32'(ram_rd_en), 32'd0);
    chk("midrst_wr_en",     32'(ram_wr_en), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("postrst_no_stale", 32'(rsp_valid), 32'd0);
    drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b1);
    chk("postrst_rd_en", 32'(ram_rd_en), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("postrst_n1_valid", 32'(rsp_valid), 32'd0);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("postrst_n2_valid", 32'(rsp_valid), 32'd1);
    chk("postrst_n2_data",  32'(rsp_data),  32'h5C);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("postrst_single_rsp", 32'(rsp_valid), 32'd0);

    // random mix against the memory model
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 4'(i), 8'($urandom_range(0, 255)), 1'b1);
    end
    for (int n = 0; n < 2000; n++) begin
      rwe = 1'($urandom_range(0, 1));
      ra  = 4'($urandom_range(0, DEPTH - 1));
      rd  = 8'($urandom_range(0, 255));
      stall = 0;
      do begin
        drive(1'b1, rwe, ra, rd, 1'($urandom_range(0, 1)));
        stall++;
      end while (!acc_flag && stall < 64);
      if (!acc_flag) begin
        chk("rand_accept_timeout", 32'(stall), 32'd0);
        break;
      end
    end
    stall = 0;
    do begin
      drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      stall++;
    end while ((exp_q.size() != 0 || rsp_valid) && stall < 100);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_contention", 32'(n_contention), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
